// File: rtl/fx_cmd_parser.sv
// fx_cmd_parser: byte-stream command parser between the FX2 slave FIFO and
// the config register file.
//   Packet: OP A2 A1 A0 LEN [LEN+1 data bytes for OP=0x55]; OP=0xAA reads
//   LEN+1 bytes starting at {A2[5:0],A1,A0} and returns them on tx.
// Ports:
//   clk_sys, rst            single clock, synchronous active-high reset
//   rx_data/rx_vld/rx_rdy   command byte stream in
//   tx_data/tx_vld/tx_rdy   read-response byte stream out
//   fx_waddr/fx_wr/fx_data  register-file write port (one-cycle strobe)
//   fx_raddr/fx_rd/fx_q     register-file read port (fx_q valid 1 cycle after fx_rd)
//   busy                    parser is mid-packet
//   err_cnt                 saturating count of bad opcodes and timeouts
// Build option: define FX_CMD_TIMEOUT_EN to abort packets that stall for
// TO_CYCLES cycles between rx bytes; otherwise the parser waits forever.
module fx_cmd_parser #(
    parameter int unsigned TO_CYCLES = 50000
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        rx_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    output logic [21:0] fx_waddr,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic [21:0] fx_raddr,
    output logic        fx_rd,
    input  logic [7:0]  fx_q,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int unsigned AW    = 22;
    localparam int unsigned DW    = 8;
    localparam logic [7:0]  OP_WR = 8'h55;
    localparam logic [7:0]  OP_RD = 8'hAA;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR2, S_ADDR1, S_ADDR0, S_LEN,
        S_WR_DATA, S_WR_STB, S_RD_REQ, S_RD_WAIT, S_RD_SEND
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   cnt_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   tx_data_q;
    logic            tx_vld_q;
    logic            fx_wr_q;
    logic            fx_rd_q;
    logic            is_wr_q;
    logic [7:0]      err_q;

    logic rx_fire, tx_fire, op_ok, bad_op, last, xfer_done, timeout;

    assign rx_fire   = rx_vld & rx_rdy;
    assign tx_fire   = tx_vld_q & tx_rdy;
    assign op_ok     = (rx_data == OP_WR) || (rx_data == OP_RD);
    assign bad_op    = (state_q == S_IDLE) && rx_fire && !op_ok;
    assign last      = (cnt_q == '0);
    // One data transfer finished: write strobe issued or read byte taken.
    assign xfer_done = (state_q == S_WR_STB) || ((state_q == S_RD_SEND) && tx_fire);

`ifdef FX_CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_wait;

    // Only states that are waiting on the rx side can time out.
    assign to_wait = (state_q == S_ADDR2) || (state_q == S_ADDR1) || (state_q == S_ADDR0) ||
                     (state_q == S_LEN)   || (state_q == S_WR_DATA);
    assign timeout = to_wait && !rx_fire && (to_cnt_q == TO_W'(TO_CYCLES - 1));

    always_comb begin
        to_cnt_d = '0;
        if (to_wait && !rx_fire && !timeout) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_to_cycles;
    assign unused_to_cycles = ^TO_CYCLES;
    assign timeout          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (rx_fire && op_ok) state_d = S_ADDR2;
            S_ADDR2:   if (rx_fire) state_d = S_ADDR1;
            S_ADDR1:   if (rx_fire) state_d = S_ADDR0;
            S_ADDR0:   if (rx_fire) state_d = S_LEN;
            S_LEN:     if (rx_fire) state_d = is_wr_q ? S_WR_DATA : S_RD_REQ;
            S_WR_DATA: if (rx_fire) state_d = S_WR_STB;
            S_WR_STB:  state_d = last ? S_IDLE : S_WR_DATA;
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_RD_SEND;
            S_RD_SEND: if (tx_fire) state_d = last ? S_IDLE : S_RD_REQ;
            default:   state_d = S_IDLE;
        endcase
        if (timeout) begin
            state_d = S_IDLE;
        end
    end

    // Decoded outputs; rx_rdy drops during reset so no byte is consumed then.
    always_comb begin
        rx_rdy = 1'b0;
        busy   = (state_q != S_IDLE);
        if (!rst) begin
            rx_rdy = (state_q == S_IDLE)  || (state_q == S_ADDR2) || (state_q == S_ADDR1) ||
                     (state_q == S_ADDR0) || (state_q == S_LEN)   || (state_q == S_WR_DATA);
        end
    end

    // Datapath and registered strobes.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            fx_wr_q   <= 1'b0;
            fx_rd_q   <= 1'b0;
            is_wr_q   <= 1'b0;
            err_q     <= '0;
        end else begin
            fx_wr_q  <= (state_d == S_WR_STB);
            fx_rd_q  <= (state_d == S_RD_REQ);
            tx_vld_q <= (state_d == S_RD_SEND);
            if (state_q == S_IDLE && rx_fire && op_ok) is_wr_q <= (rx_data == OP_WR);
            if (state_q == S_ADDR2 && rx_fire) addr_q[21:16] <= rx_data[5:0];
            if (state_q == S_ADDR1 && rx_fire) addr_q[15:8]  <= rx_data;
            if (state_q == S_ADDR0 && rx_fire) addr_q[7:0]   <= rx_data;
            if (state_q == S_LEN && rx_fire)   cnt_q         <= rx_data;
            if (state_q == S_WR_DATA && rx_fire) wdata_q     <= rx_data;
            if (state_q == S_RD_WAIT) tx_data_q <= fx_q;
            if (xfer_done) begin
                addr_q <= addr_q + AW'(1);
                if (!last) cnt_q <= cnt_q - DW'(1);
            end
            // Bad opcode (IDLE only) and timeout (non-IDLE only) count as one event.
            if ((bad_op || timeout) && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign fx_waddr = addr_q;
    assign fx_raddr = addr_q;
    assign fx_data  = wdata_q;
    assign fx_wr    = fx_wr_q;
    assign fx_rd    = fx_rd_q;
    assign tx_data  = tx_data_q;
    assign tx_vld   = tx_vld_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_fx_cmd_parser.sv
// Testbench for fx_cmd_parser: directed packets plus randomized packets
// checked against a packet-level reference model (expected write, read
// and tx queues, expected error count).
module tb_fx_cmd_parser;

    localparam int TO = 16;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic        rx_rdy;
    logic [7:0]  tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic [21:0] fx_waddr;
    logic        fx_wr;
    logic [7:0]  fx_data;
    logic [21:0] fx_raddr;
    logic        fx_rd;
    logic [7:0]  fx_q;
    logic        busy;
    logic [7:0]  err_cnt;

    fx_cmd_parser #(.TO_CYCLES(TO)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_rdy  (rx_rdy),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .fx_waddr(fx_waddr),
        .fx_wr   (fx_wr),
        .fx_data (fx_data),
        .fx_raddr(fx_raddr),
        .fx_rd   (fx_rd),
        .fx_q    (fx_q),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_wr = 0;
    int n_rd = 0;
    int exp_err = 0;
    logic hold_tx = 1'b0;

    logic [21:0] wq_a[$];
    logic [7:0]  wq_d[$];
    logic [21:0] rq_a[$];
    logic [7:0]  tq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Register-file read slave: data valid only in the cycle after fx_rd.
    initial begin
        logic        rd;
        logic [21:0] a;
        fx_q = 8'h00;
        forever begin
            @(negedge clk_sys);
            rd = fx_rd;
            a  = fx_raddr;
            @(posedge clk_sys);
            #1;
            fx_q = rd ? ~a[7:0] : 8'($urandom);
        end
    end

    // FX2 tx side: random back-pressure unless held off.
    initial begin
        tx_rdy = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            tx_rdy = hold_tx ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: compare every strobe and tx transfer against the model queues.
    always @(negedge clk_sys) begin
        if (!rst) begin
            if (rx_vld && rx_rdy) acc_cyc = cyc;
            if (fx_wr || fx_rd) chk("wr_rd_excl", 32'(fx_wr & fx_rd), 0);
            if (fx_wr) begin
                n_wr++;
                if (wq_a.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    chk("wr_addr", 32'(fx_waddr), 32'(wq_a.pop_front()));
                    chk("wr_data", 32'(fx_data), 32'(wq_d.pop_front()));
                    chk("wr_latency", 32'(cyc - acc_cyc), 1);
                end
            end
            if (fx_rd) begin
                n_rd++;
                if (rq_a.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_addr", 32'(fx_raddr), 32'(rq_a.pop_front()));
            end
            if (tx_vld && tx_rdy) begin
                if (tq.size() == 0) chk("tx_unexpected", 1, 0);
                else chk("tx_data", 32'(tx_data), 32'(tq.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk_sys);
        while (!rx_rdy && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        if (!rx_rdy) chk("rx_accept_timeout", 0, 1);
        @(posedge clk_sys);
        #1;
        rx_vld  = 1'b0;
        rx_data = 8'($urandom);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic bad_byte(input logic [7:0] b);
        send_byte(b);
        if (exp_err < 255) exp_err++;
    endtask

    task automatic run_write(input logic [21:0] a, input logic [7:0] len,
                             input logic [1:0] hi, input logic [7:0] d0);
        logic [7:0] d;
        send_byte(8'h55);
        send_byte({hi, a[21:16]});
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(len);
        for (int i = 0; i <= int'(len); i++) begin
            d = (i == 0) ? d0 : 8'($urandom);
            wq_a.push_back(22'(a + 22'(i)));
            wq_d.push_back(d);
            send_byte(d);
        end
    endtask

    task automatic run_read(input logic [21:0] a, input logic [7:0] len, input logic [1:0] hi);
        logic [21:0] ra;
        for (int i = 0; i <= int'(len); i++) begin
            ra = 22'(a + 22'(i));
            rq_a.push_back(ra);
            tq.push_back(~ra[7:0]);
        end
        send_byte(8'hAA);
        send_byte({hi, a[21:16]});
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(len);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk_sys);
        while (busy && t < 3000) begin
            @(negedge clk_sys);
            t++;
        end
        chk("busy_end", 32'(busy), 0);
        chk("wr_left", 32'(wq_a.size()), 0);
        chk("rd_left", 32'(rq_a.size()), 0);
        chk("tx_left", 32'(tq.size()), 0);
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_vld", 32'(tx_vld), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_fx_wr", 32'(fx_wr), 0);
        chk("rst_fx_rd", 32'(fx_rd), 0);
        chk("rst_waddr", 32'(fx_waddr), 0);
        chk("rst_raddr", 32'(fx_raddr), 0);
        chk("rst_fx_data", 32'(fx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_rx_rdy", 32'(rx_rdy), 0);
    endtask

    initial begin
        logic [21:0] a;
        logic [7:0]  b;
        int          k;
        int          snap;
        int          t;

        rst     = 1'b1;
        rx_vld  = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk_reset_outputs();
        @(posedge clk_sys);
        #1;
        rst = 1'b0;

        // Single write at 0x001234.
        snap = n_wr;
        run_write(22'h001234, 8'd0, 2'b00, 8'hA5);
        wait_idle();
        chk("wr_count_single", 32'(n_wr - snap), 1);

        // Two-byte read wrapping 0x3FFFFF -> 0x000000.
        snap = n_rd;
        run_read(22'h3FFFFF, 8'd1, 2'b00);
        wait_idle();
        chk("rd_count_wrap", 32'(n_rd - snap), 2);

        // Bad opcode, then write with A2[7:6] set.
        bad_byte(8'h7E);
        @(negedge clk_sys);
        chk("err_after_bad", 32'(err_cnt), 1);
        @(posedge clk_sys);
        #1;
        run_write(22'h000010, 8'd0, 2'b11, 8'h5A);
        wait_idle();

        // Read held off by tx_rdy=0 for 20 cycles.
        hold_tx = 1'b1;
        snap    = n_rd;
        a       = 22'($urandom);
        run_read(a, 8'd0, 2'($urandom));
        t = 0;
        @(negedge clk_sys);
        while (!tx_vld && t < 50) begin
            @(negedge clk_sys);
            t++;
        end
        b = ~a[7:0];
        repeat (20) begin
            chk("tx_hold_vld", 32'(tx_vld), 1);
            chk("tx_hold_data", 32'(tx_data), 32'(b));
            @(negedge clk_sys);
        end
        chk("rd_once", 32'(n_rd - snap), 1);
        hold_tx = 1'b0;
        wait_idle();

`ifdef FX_CMD_TIMEOUT_EN
        // Stall after 55 00: abort after TO idle cycles, no write issued.
        snap = n_wr;
        send_byte(8'h55);
        send_byte(8'h00);
        t = 0;
        @(negedge clk_sys);
        while (busy && t < 100) begin
            @(negedge clk_sys);
            t++;
        end
        chk("to_stall_cycles", 32'(cyc - acc_cyc - 1), 32'(TO));
        if (exp_err < 255) exp_err++;
        chk("to_err", 32'(err_cnt), 32'(exp_err));
        chk("to_no_wr", 32'(n_wr - snap), 0);
        @(posedge clk_sys);
        #1;
`endif

        // Longest burst (256 writes) crossing the address wrap.
        run_write(22'h3FFF80, 8'd255, 2'b01, 8'h3C);
        wait_idle();

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            k = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) a = 22'h3FFFFF - 22'($urandom_range(0, 2));
            else a = 22'($urandom);
            if (k == 0) begin
                do b = 8'($urandom); while (b == 8'h55 || b == 8'hAA);
                bad_byte(b);
            end else if (k < 3) begin
                run_write(a, 8'($urandom_range(0, 5)), 2'($urandom), 8'($urandom));
            end else begin
                run_read(a, 8'($urandom_range(0, 5)), 2'($urandom));
            end
            wait_idle();
        end

        // err_cnt saturation.
        for (int i = 0; i < 260; i++) bad_byte(8'h13);
        wait_idle();
        chk("err_saturated", 32'(err_cnt), 255);

        // Reset during WR_DATA of a 4-byte burst; the byte presented in reset is dropped.
        wq_a.push_back(22'h000200);
        wq_d.push_back(8'hC3);
        send_byte(8'h55);
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h03);
        send_byte(8'hC3);
        repeat (3) begin
            @(posedge clk_sys);
            #1;
        end
        rst     = 1'b1;
        rx_vld  = 1'b1;
        rx_data = 8'h77;
        @(negedge clk_sys);
        chk("rst_rx_rdy_now", 32'(rx_rdy), 0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk_reset_outputs();
        chk("rst_partial_wr", 32'(wq_a.size()), 0);
        @(posedge clk_sys);
        #1;
        rst     = 1'b0;
        rx_vld  = 1'b0;
        exp_err = 0;
        run_write(22'($urandom), 8'd2, 2'b00, 8'h99);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fx_cmd_parser.md
FX_CMD_PARSER -- requirements
Module: fx_cmd_parser

Interface
REQ-001 The block SHALL have parameter TO_CYCLES, default 50000, meaning idle cycles between accepted rx bytes before an incomplete packet is aborted.
REQ-002 The block SHALL have port clk_sys  input  1  system clock; the block uses one clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port rx_data  input  8  command byte from the FX2 slave-FIFO side.
REQ-005 The block SHALL have port rx_vld  input  1  rx_data valid.
REQ-006 The block SHALL have port rx_rdy  output  1  parser can accept a byte.
REQ-007 The block SHALL have port tx_data  output  8  read-response byte toward FX2.
REQ-008 The block SHALL have port tx_vld  output  1  tx_data valid.
REQ-009 The block SHALL have port tx_rdy  input  1  FX2 side accepts tx byte.
REQ-010 The block SHALL have port fx_waddr  output  22  write address to the config register file.
REQ-011 The block SHALL have port fx_wr  output  1  one-cycle write strobe.
REQ-012 The block SHALL have port fx_data  output  8  write data.
REQ-013 The block SHALL have port fx_raddr  output  22  read address.
REQ-014 The block SHALL have port fx_rd  output  1  one-cycle read strobe.
REQ-015 The block SHALL have port fx_q  input  8  read data, valid exactly 1 cycle after fx_rd.
REQ-016 The block SHALL have port busy  output  1  state is not IDLE.
REQ-017 The block SHALL have port err_cnt  output  8  saturating count of bad opcodes and timeouts.

Function
REQ-018 An rx byte transfer SHALL occur only on a cycle where rx_vld and rx_rdy are both 1; a tx transfer SHALL occur only when tx_vld and tx_rdy are both 1.
REQ-019 The packet format SHALL be: OP, A2, A1, A0, LEN, then LEN+1 data bytes for a write (OP=0x55) or no further bytes for a read (OP=0xAA). The address is big-endian {A2[5:0],A1,A0}, and A2[7:6] are ignored.
REQ-020 The FSM states SHALL be IDLE, ADDR2, ADDR1, ADDR0, LEN, WR_DATA, WR_STB, RD_REQ, RD_WAIT, RD_SEND.
REQ-021 rx_rdy SHALL be 1 in IDLE, ADDR2, ADDR1, ADDR0, LEN and WR_DATA only.
REQ-022 In IDLE, OP=0x55 or 0xAA SHALL go to ADDR2; any other byte SHALL be consumed, increment err_cnt and keep the FSM in IDLE.
REQ-023 After LEN is accepted, the remaining-count register SHALL load LEN (8 bits, so 1..256 transfers). The FSM SHALL go to WR_DATA for a write and RD_REQ for a read.
REQ-024 WR_DATA SHALL accept a byte and go to WR_STB. WR_STB SHALL assert fx_wr for exactly one cycle with fx_waddr/fx_data stable during that cycle.
REQ-025 After each write or read transfer the address SHALL increment modulo 2^22 (0x3FFFFF wraps to 0x000000).
REQ-026 After each transfer the count SHALL decrement. At count 0 the FSM SHALL return to IDLE; otherwise it SHALL go to WR_DATA or RD_REQ.
REQ-027 RD_REQ SHALL assert fx_rd for one cycle. RD_WAIT SHALL follow. The FSM SHALL capture fx_q into tx_data on the RD_WAIT cycle and enter RD_SEND with tx_vld=1.
REQ-028 tx_vld and tx_data SHALL hold until tx_rdy=1, and the FSM SHALL wait in RD_SEND indefinitely.
REQ-029 fx_wr and fx_rd SHALL never be asserted in the same cycle, and neither SHALL be asserted outside WR_STB or RD_REQ.
REQ-030 fx_waddr and fx_raddr SHALL both be driven from the single address register.
REQ-031 err_cnt SHALL saturate at 0xFF. A bad opcode and a timeout in the same cycle SHALL count once.

Reset
REQ-032 When rst=1 at a clk_sys edge, the block SHALL enter IDLE and set rx_rdy=0 for that cycle, tx_vld=0, tx_data=0, fx_wr=0, fx_rd=0, fx_waddr/fx_raddr=0, fx_data=0, busy=0, err_cnt=0, count=0 and timeout counter=0.
REQ-033 A reset asserted mid-packet SHALL discard the partial packet, and the byte presented during reset SHALL NOT be consumed.

Configuration
REQ-034 With macro FX_CMD_TIMEOUT_EN defined, in ADDR2..WR_DATA the timeout counter SHALL count cycles without an rx transfer. Reaching TO_CYCLES SHALL return the FSM to IDLE, increment err_cnt, and issue no fx_wr.
REQ-035 The timeout counter SHALL clear on every accepted byte and in any read or IDLE state.
REQ-036 Without FX_CMD_TIMEOUT_EN, the block SHALL contain no timeout logic and SHALL wait indefinitely for rx bytes.

Verification
REQ-037 Stimulus rx 55 00 12 34 00 A5 -> one fx_wr pulse, fx_waddr=0x001234, fx_data=0xA5, fx_wr 1 cycle after the A5 byte is accepted, busy=0 afterward.
REQ-038 Stimulus rx AA 3F FF FF 01, fx_q = ~addr[7:0], tx_rdy=1 -> fx_rd at 0x3FFFFF then 0x000000, tx bytes 0x00 then 0xFF.
REQ-039 Stimulus rx 7E then 55 C0 00 10 00 5A -> err_cnt=1, then write to 0x000010 data 0x5A (A2[7:6] ignored).
REQ-040 Stimulus read LEN=0 with tx_rdy held 0 for 20 cycles -> tx_vld=1 and tx_data stable for all 20 cycles, exactly one fx_rd, and the transfer completes on tx_rdy=1.
REQ-041 With FX_CMD_TIMEOUT_EN and TO_CYCLES=16, stimulus rx 55 00 then stall -> return to IDLE after 16 cycles, err_cnt=1, no fx_wr.
REQ-042 Stimulus rst=1 during WR_DATA of a 4-byte burst -> all outputs at reset values the next cycle, and a subsequent clean packet executes normally.
